// File: rtl/ula_md.sv
// ---------------------------------------------------------------------------
// ula_md : iterative RV64M multiply/divide unit (execute stage)
//
// Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on N-bit operands. When
// word=1 it executes the *W forms (MULW/DIVW/DIVUW/REMW/REMUW). Products use
// a one-bit-per-cycle shift-add loop, quotients a restoring divider. Both
// loops share the acc/lo/mcand registers. Division by zero and signed
// overflow skip the loop and take a one-cycle special-case path.
//
// Parameters:
//   N          datapath width (>= 32, even). When N == 32, word is ignored.
//
// Optional feature:
//   ULA_MD_KILL_EN  adds a 'kill' input that flushes any in-flight
//                   operation and blocks acceptance while high in IDLE.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   kill       (ULA_MD_KILL_EN only) pipeline flush, lower priority than reset
//   in_valid   request carries a valid operation
//   in_ready   unit idle and able to accept a request
//   word       *W mode: operate on [31:0], sign-extend the 32-bit result
//   MDControl  funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                      100 DIV 101 DIVU 110 REM 111 REMU
//   dataA      rs1 operand
//   dataB      rs2 operand
//   out_valid  result valid
//   out_ready  consumer takes the result
//   MDOut      result
//   Zero       MDOut == 0, qualified by out_valid
//   DivZero    division/remainder by zero, qualified by out_valid
// ---------------------------------------------------------------------------
module ula_md #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
`ifdef ULA_MD_KILL_EN
    input  logic         kill,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         word,
    input  logic [2:0]   MDControl,
    input  logic [N-1:0] dataA,
    input  logic [N-1:0] dataB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] MDOut,
    output logic         Zero,
    output logic         DivZero
);

    localparam int CW = $clog2(N);

    localparam logic [N-1:0]   ZERO_N   = {N{1'b0}};
    localparam logic [N-1:0]   ONES_N   = {N{1'b1}};
    localparam logic [2*N-1:0] ZERO_2N  = {(2*N){1'b0}};
    localparam logic [N-1:0]   MIN_FULL = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]   MIN32_Z  = N'(32'h8000_0000);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_FIX  = 3'd2,
        ST_SPEC = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Sign-extend bit 31 across the full width (safe for N == 32).
    function automatic logic [N-1:0] sext32(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (i < 32) ? x[i] : x[31];
        end
        return r;
    endfunction

    // Keep bits [31:0], clear everything above.
    function automatic logic [N-1:0] zext32(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = (i < 32) ? x[i] : 1'b0;
        end
        return r;
    endfunction

    state_t         state_r;
    logic [N-1:0]   acc_r;      // product high half / partial remainder
    logic [N-1:0]   lo_r;       // multiplier -> product low half / dividend -> quotient
    logic [N-1:0]   mcand_r;    // multiplicand / divisor magnitude
    logic [CW-1:0]  cnt_r;
    logic           div_r;
    logic           rem_r;
    logic           hi_r;
    logic           word_r;
    logic           neg_r;
    logic           divz_r;

    logic           kill_s;
    logic           accept_s;
    logic           word_eff_s;
    logic           op_div_s;
    logic           sign_a_op_s;
    logic           sign_b_op_s;
    logic           hi_sel_s;
    logic [N-1:0]   a_ext_s;
    logic [N-1:0]   b_ext_s;
    logic           neg_a_s;
    logic           neg_b_s;
    logic [N-1:0]   mag_a_s;
    logic [N-1:0]   mag_b_s;
    logic [N-1:0]   min_eff_s;
    logic           b_zero_s;
    logic           ovf_s;
    logic           spec_s;
    logic           neg_res_s;
    logic [N-1:0]   div_lo_init_s;

    logic [N:0]     mul_sum_s;
    logic [N:0]     div_shift_s;
    logic           div_ge_s;
    logic [N-1:0]   div_diff_s;

    logic [2*N-1:0] full_s;
    logic [2*N-1:0] full_fix_s;
    logic [N-1:0]   div_raw_s;
    logic [N-1:0]   div_fix_s;
    logic [N-1:0]   fix_res_s;
    logic [N-1:0]   spec_raw_s;
    logic [N-1:0]   spec_res_s;

`ifdef ULA_MD_KILL_EN
    assign kill_s = kill;
`else
    assign kill_s = 1'b0;
`endif

    // Ready only in IDLE; reset forces it low so a request during reset is dropped.
    assign in_ready = (state_r == ST_IDLE) && !reset;
    assign accept_s = in_valid && in_ready && !kill_s;

    // Request decode: effective operands, magnitudes, result sign, special cases.
    always_comb begin
        word_eff_s = word && (N > 32);
        op_div_s   = MDControl[2];

        if (op_div_s) begin
            sign_a_op_s = !MDControl[0];
            sign_b_op_s = !MDControl[0];
            hi_sel_s    = 1'b0;
        end else if (word_eff_s) begin
            // Any multiply in word mode runs as MULW: unsigned low product.
            sign_a_op_s = 1'b0;
            sign_b_op_s = 1'b0;
            hi_sel_s    = 1'b0;
        end else begin
            sign_a_op_s = (MDControl[1:0] == 2'b01) || (MDControl[1:0] == 2'b10);
            sign_b_op_s = (MDControl[1:0] == 2'b01);
            hi_sel_s    = (MDControl[1:0] != 2'b00);
        end

        if (word_eff_s) begin
            a_ext_s   = sign_a_op_s ? sext32(dataA) : zext32(dataA);
            b_ext_s   = sign_b_op_s ? sext32(dataB) : zext32(dataB);
            min_eff_s = sext32(MIN32_Z);
        end else begin
            a_ext_s   = dataA;
            b_ext_s   = dataB;
            min_eff_s = MIN_FULL;
        end

        neg_a_s = sign_a_op_s && a_ext_s[N-1];
        neg_b_s = sign_b_op_s && b_ext_s[N-1];
        mag_a_s = neg_a_s ? (ZERO_N - a_ext_s) : a_ext_s;
        mag_b_s = neg_b_s ? (ZERO_N - b_ext_s) : b_ext_s;

        b_zero_s = (b_ext_s == ZERO_N);
        ovf_s    = op_div_s && !MDControl[0] && (a_ext_s == min_eff_s) && (b_ext_s == ONES_N);
        spec_s   = op_div_s && (b_zero_s || ovf_s);

        // Remainder follows the dividend sign; product/quotient follow sA^sB.
        if (op_div_s && MDControl[1]) begin
            neg_res_s = neg_a_s;
        end else begin
            neg_res_s = neg_a_s ^ neg_b_s;
        end

        // Left-align a word dividend so the loop always consumes lo_r[N-1].
        if (word_eff_s) begin
            div_lo_init_s = mag_a_s << (N - 32);
        end else begin
            div_lo_init_s = mag_a_s;
        end
    end

    // One iteration of the shift-add multiplier and the restoring divider.
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
        end else begin
            mul_sum_s = {1'b0, acc_r};
        end
        div_shift_s = {acc_r, lo_r[N-1]};
        div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
        // When div_ge_s holds the difference is below the divisor, so N bits suffice.
        div_diff_s  = div_shift_s[N-1:0] - mcand_r;
    end

    // Final correction: sign fix-up, half select, word sign-extension.
    always_comb begin
        full_s     = {acc_r, lo_r};
        full_fix_s = neg_r ? (ZERO_2N - full_s) : full_s;
        div_raw_s  = rem_r ? acc_r : lo_r;
        div_fix_s  = neg_r ? (ZERO_N - div_raw_s) : div_raw_s;

        if (div_r) begin
            fix_res_s = word_r ? sext32(div_fix_s) : div_fix_s;
        end else if (word_r) begin
            // After 32 iterations the low product word sits at the top of lo_r.
            fix_res_s = sext32(lo_r >> (N - 32));
        end else if (hi_r) begin
            fix_res_s = full_fix_s[2*N-1:N];
        end else begin
            fix_res_s = full_fix_s[N-1:0];
        end
    end

    // Special-case result: divide by zero or most-negative / -1.
    always_comb begin
        if (divz_r) begin
            spec_raw_s = rem_r ? lo_r : ONES_N;
        end else begin
            spec_raw_s = rem_r ? ZERO_N : (word_r ? MIN32_Z : MIN_FULL);
        end
        spec_res_s = word_r ? sext32(spec_raw_s) : spec_raw_s;
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            acc_r     <= ZERO_N;
            lo_r      <= ZERO_N;
            mcand_r   <= ZERO_N;
            cnt_r     <= {CW{1'b0}};
            div_r     <= 1'b0;
            rem_r     <= 1'b0;
            hi_r      <= 1'b0;
            word_r    <= 1'b0;
            neg_r     <= 1'b0;
            divz_r    <= 1'b0;
            out_valid <= 1'b0;
            MDOut     <= ZERO_N;
            Zero      <= 1'b0;
            DivZero   <= 1'b0;
        end else if (kill_s && (state_r != ST_IDLE)) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            Zero      <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        div_r  <= op_div_s;
                        rem_r  <= MDControl[1];
                        hi_r   <= hi_sel_s;
                        word_r <= word_eff_s;
                        neg_r  <= neg_res_s;
                        divz_r <= b_zero_s;
                        acc_r  <= ZERO_N;
                        cnt_r  <= word_eff_s ? CW'(31) : CW'(N - 1);
                        if (spec_s) begin
                            lo_r    <= a_ext_s;
                            mcand_r <= b_ext_s;
                            state_r <= ST_SPEC;
                        end else if (op_div_s) begin
                            lo_r    <= div_lo_init_s;
                            mcand_r <= mag_b_s;
                            state_r <= ST_CALC;
                        end else begin
                            lo_r    <= mag_b_s;
                            mcand_r <= mag_a_s;
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (div_r) begin
                        acc_r <= div_ge_s ? div_diff_s : div_shift_s[N-1:0];
                        lo_r  <= {lo_r[N-2:0], div_ge_s};
                    end else begin
                        acc_r <= mul_sum_s[N:1];
                        lo_r  <= {mul_sum_s[0], lo_r[N-1:1]};
                    end
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_FIX: begin
                    MDOut     <= fix_res_s;
                    Zero      <= (fix_res_s == ZERO_N);
                    DivZero   <= 1'b0;
                    out_valid <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_SPEC: begin
                    MDOut     <= spec_res_s;
                    Zero      <= (spec_res_s == ZERO_N);
                    DivZero   <= divz_r;
                    out_valid <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        Zero      <= 1'b0;
                        DivZero   <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    Zero      <= 1'b0;
                    DivZero   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_md.sv
// ---------------------------------------------------------------------------
// tb_ula_md : directed self-checking bench for ula_md (N = 64).
// Each vector carries a hand-computed result, flag values and latency.
// ---------------------------------------------------------------------------
module tb_ula_md;

    localparam int N = 64;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         word = 1'b0;
    logic [2:0]   MDControl = 3'b000;
    logic [N-1:0] dataA = 64'd0;
    logic [N-1:0] dataB = 64'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] MDOut;
    logic         Zero;
    logic         DivZero;
`ifdef ULA_MD_KILL_EN
    logic         kill = 1'b0;
`endif

    int check_cnt = 0;
    int fail_cnt  = 0;

    ula_md #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef ULA_MD_KILL_EN
        .kill      (kill),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .word      (word),
        .MDControl (MDControl),
        .dataA     (dataA),
        .dataB     (dataB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MDOut     (MDOut),
        .Zero      (Zero),
        .DivZero   (DivZero)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure latency, check result, then hold and retire it.
    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_lat,
                          input logic exp_dz, input int hold);
        int cyc;
        @(negedge clk);
        check_value({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        MDControl = op;
        word      = w;
        dataA     = a;
        dataB     = b;
        @(posedge clk);
        #1;
        // Scramble inputs: the unit must work from the latched copies.
        in_valid  = 1'b0;
        MDControl = ~op;
        word      = ~w;
        dataA     = ~a;
        dataB     = ~b;
        cyc = 1;
        @(negedge clk);
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_value({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
        check_value({tag, "/MDOut"}, MDOut, exp_res);
        check_value({tag, "/Zero"}, 64'(Zero), 64'(exp_res == 64'd0));
        check_value({tag, "/DivZero"}, 64'(DivZero), 64'(exp_dz));
        check_value({tag, "/in_ready_done"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_value({tag, "/hold_MDOut"}, MDOut, exp_res);
            check_value({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            check_value({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_value({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
        check_value({tag, "/divz_drop"}, 64'(DivZero), 64'd0);
    endtask

    // Watch for a stray result over a window of cycles.
    task automatic expect_no_result(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_value(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst/in_ready", 64'(in_ready), 64'd0);
        check_value("rst/out_valid", 64'(out_valid), 64'd0);
        check_value("rst/MDOut", MDOut, 64'd0);
        check_value("rst/Zero", 64'(Zero), 64'd0);
        check_value("rst/DivZero", 64'(DivZero), 64'd0);
        reset = 1'b0;
        #1;
        check_value("rst/in_ready_after", 64'(in_ready), 64'd1);

        // Full-width multiplies
        run_op("mul", OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, 66, 1'b0, 0);
        run_op("mulhu", OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b0, 0);
        run_op("mulh", OP_MULH, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 66, 1'b0, 0);
        run_op("mulhsu", OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0, 0);

        // Full-width divides
        run_op("div", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0, 0);
        run_op("rem", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0, 0);
        run_op("remu_hold", OP_REMU, 1'b0, 64'd100, 64'd7,
               64'd2, 66, 1'b0, 5);

        // Special cases
        run_op("divu_z", OP_DIVU, 1'b0, 64'd5, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 0);
        run_op("remu_z", OP_REMU, 1'b0, 64'd5, 64'd0,
               64'd5, 2, 1'b1, 0);
        run_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 2, 1'b0, 0);
        run_op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 2, 1'b0, 0);

        // Word mode
        run_op("divw", OP_DIV, 1'b1, 64'h0000_0001_FFFF_FFF8, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFC, 34, 1'b0, 0);
        run_op("mulw", OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b0, 0);
        run_op("divuw", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0, 0);
        run_op("mulhu_w", OP_MULHU, 1'b1, 64'h0000_0001_0000_0003, 64'd5,
               64'd15, 34, 1'b0, 0);
        run_op("divuw_z", OP_DIVU, 1'b1, 64'd9, 64'h0000_0001_0000_0000,
               64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 0);
        run_op("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 2, 1'b0, 0);

        // Reset abort in CALC cycle 10
        @(negedge clk);
        in_valid  = 1'b1;
        MDControl = OP_DIVU;
        word      = 1'b0;
        dataA     = 64'd1000;
        dataB     = 64'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_value("abort/in_ready_in_reset", 64'(in_ready), 64'd0);
        check_value("abort/out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_value("abort/in_ready_after", 64'(in_ready), 64'd1);
        expect_no_result("abort/no_result", 80);

        // Unit still usable after the abort
        run_op("post_abort", OP_DIVU, 1'b0, 64'd1000, 64'd3,
               64'd333, 66, 1'b0, 0);

`ifdef ULA_MD_KILL_EN
        // Kill while in CALC
        @(negedge clk);
        in_valid  = 1'b1;
        MDControl = OP_MUL;
        word      = 1'b0;
        dataA     = 64'd3;
        dataB     = 64'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check_value("kill/in_ready", 64'(in_ready), 64'd1);
        check_value("kill/out_valid", 64'(out_valid), 64'd0);
        expect_no_result("kill/no_result", 80);

        // Kill in IDLE blocks acceptance
        @(negedge clk);
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check_value("kill_idle/in_ready", 64'(in_ready), 64'd1);
        expect_no_result("kill_idle/no_result", 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ula_md.md
Name: ula_md

Overview:
- Iterative multiply/divide unit for the RV64M extension. It sits beside the combinational ULA in the execute stage.
- Supports MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on N-bit operands. Supports the *W forms (MULW/DIVW/DIVUW/REMW/REMUW) via the word input.
- Uses a one-bit-per-cycle shift-add multiplier and a restoring divider.
- Operands are accepted on an in_valid/in_ready handshake; results are returned on an out_valid/out_ready handshake.

Parameters:
- N, 64, datapath width. N >= 32 and N even. When N == 32, the word input is ignored.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request carries a valid operation
- in_ready  output  1  unit idle and able to accept a request
- word  input  1  RV64 *W mode: operate on bits [31:0], sign-extend the 32-bit result
- MDControl  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- dataA  input  N  rs1 operand
- dataB  input  N  rs2 operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes the result
- MDOut  output  N  result
- Zero  output  1  MDOut == 0, qualified by out_valid
- DivZero  output  1  division/remainder with divisor 0, qualified by out_valid

Behaviour:
- Reset values: state IDLE, out_valid=0, MDOut=0, Zero=0, DivZero=0. in_ready=0 while reset is high and 1 in the first cycle after reset.
- in_ready = (state == IDLE).
- A request is accepted on the edge where in_valid && in_ready. Operands, opcode and word are latched at that edge; later input changes are ignored.

States:
- IDLE: on accept, go to SPEC if the operation is a special case, else to CALC.
- CALC: runs W iterations, where W = 32 if (word && N > 32), else W = N. An iteration counter counts W-1 down to 0; leave for FIX when it reaches 0.
- FIX: one cycle. Applies sign correction (negate quotient/remainder/product as needed), selects the high or low half, and applies word sign-extension. Then go to DONE.
- SPEC: one cycle. Loads the special-case result, then goes to DONE.
- DONE: out_valid=1 and outputs held stable until out_ready. On out_valid && out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle turnaround.

Latency:
- out_valid rises after accept edge + W + 2 (66 cycles for N=64, 34 for *W).
- Special cases: out_valid rises after accept edge + 2.

Signed handling:
- Take magnitudes of signed operands (DIV/REM/MULH signed operands, MULHSU rs1 only) and iterate unsigned.
- Result signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.

Word mode:
- Operands are dataA[31:0] and dataB[31:0], sign- or zero-extended per opcode.
- Result[31:0] is sign-extended to N bits, including DIVUW and REMUW.
- word=1 with MULH/MULHSU/MULHU is executed as MULW.

Special cases (SPEC path):
- Divisor 0: DIV/DIVU quotient = all ones (of the effective width, then extended). REM/REMU result = dividend. DivZero=1.
- Signed overflow (most-negative / -1): DIV result = most negative; REM result = 0.

Wrap-around and reset:
- Products are truncated modulo 2^W for MUL/MULW; there is no overflow flag.
- Reset in any state aborts the operation. Next cycle: IDLE, out_valid=0, and no partial result is ever presented.
- Simultaneous in_valid and reset: reset wins and the request is dropped.

Optional Feature:
- Macro: ULA_MD_KILL_EN.
- When defined, an input port kill (1 bit) is added.
  - kill=1 in CALC/FIX/SPEC/DONE forces IDLE at the next edge, drops out_valid and discards the result. This is used for pipeline flush.
  - kill in IDLE blocks acceptance in that cycle.
  - kill has lower priority than reset.
- When undefined: no kill port; an operation always runs to DONE.

Test Plan:
- MUL N=64, A=7, B=0xFFFF_FFFF_FFFF_FFFD -> MDOut=0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 66 cycles after accept, Zero=0.
- MULHU A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0, Zero=1. MULHSU A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV A=-7, B=2 -> 0xFFFF_FFFF_FFFF_FFFD. REM -> 0xFFFF_FFFF_FFFF_FFFF. DIVU A=5, B=0 -> all ones, DivZero=1, out_valid 2 cycles after accept. REMU A=5, B=0 -> 5.
- DIV A=0x8000_0000_0000_0000, B=-1 -> 0x8000_0000_0000_0000. REM -> 0. Both on the 2-cycle SPEC latency.
- Word mode:
  - DIVW A=0x0000_0001_FFFF_FFF8, B=2 -> 0xFFFF_FFFF_FFFF_FFFC with 34-cycle latency.
  - MULW A=0x7FFF_FFFF, B=2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - DIVUW A=0xFFFF_FFFF, B=1 -> 0xFFFF_FFFF_FFFF_FFFF.
- Handshake and abort:
  - Hold out_ready=0 for 5 cycles in DONE -> MDOut stable, in_ready=0; accept proceeds after the out handshake.
  - Assert reset in CALC cycle 10 -> out_valid never rises, in_ready=1 the cycle after reset drops.
  - With ULA_MD_KILL_EN, kill in CALC -> IDLE next edge, no result.
